hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard and control unit for the 5-stage accumulator core.
- Tracks in-flight register writes in a shift scoreboard of DEPTH slots and detects read-after-write hazards for the instruction in ID.
- Produces stall, flush, issue and a forwarding-source select for the ID/EX operand.
- Sits beside the ID stage and takes branch resolution from MEM. Generalises the fixed core to any register-address width, pipeline depth and branch stage, with optional forwarding.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the accumulator pipeline: a shift scoreboard of
// in-flight register writes drives stall, flush, issue and operand forwarding.
module hazard_ctrl #(
  parameter int NREG_BITS = 2,
  parameter int DEPTH     = 3,
  parameter int BR_SLOT   = 1,
  parameter int FWD_EN    = 1,
  parameter int CNT_W     = 8,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs,
  input  logic                 id_rs_used,
  input  logic [NREG_BITS-1:0] id_rd,
  input  logic                 id_wr,
  input  logic                 id_load,
  input  logic                 br_taken,
  output logic                 stall,
  output logic                 flush,
  output logic                 issue,
  output logic [SEL_W-1:0]     fwd_sel,
  output logic [SEL_W-1:0]     pending,
  output logic [CNT_W-1:0]     stall_cnt
);

  // A load result only exists once the load has reached MEM (slot 1).
  localparam int LOAD_READY = 1;

  logic [DEPTH-1:0]     slot_v_q, slot_v_d;
  logic [DEPTH-1:0]     slot_load_q, slot_load_d;
  logic [NREG_BITS-1:0] slot_rd_q [DEPTH];
  logic [NREG_BITS-1:0] slot_rd_d [DEPTH];
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]     match;
  logic                 hit;
  logic                 hit_load;
  logic [SEL_W-1:0]     hit_idx;
  logic                 hazard_stall;
  logic [SEL_W-1:0]     pending_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = slot_v_q[gi] && (slot_rd_q[gi] == id_rs) && id_valid && id_rs_used;
    end
  endgenerate

  // Scan oldest to youngest so the smallest matching slot is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit      = 1'b1;
        hit_load = slot_load_q[k];
        hit_idx  = SEL_W'(k);
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      hazard_stall = hit && hit_load && (hit_idx < SEL_W'(LOAD_READY));
    end else begin
      hazard_stall = hit;
    end
  end

  assign stall = hazard_stall && !br_taken;
  assign flush = br_taken;
  assign issue = id_valid && !stall && !br_taken;

  always_comb begin
    fwd_sel = '0;
    if ((FWD_EN != 0) && hit && !hazard_stall && !br_taken) begin
      fwd_sel = hit_idx + SEL_W'(1);
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_cnt = pending_cnt + SEL_W'(slot_v_q[k]);
    end
  end

  assign pending   = pending_cnt;
  assign stall_cnt = stall_cnt_q;

  // Entries leaving slots younger than the branch are squashed as they shift.
  always_comb begin
    slot_v_d[0]    = issue && id_wr;
    slot_rd_d[0]   = id_rd;
    slot_load_d[0] = issue && id_wr && id_load;
    for (int k = 1; k < DEPTH; k++) begin
      slot_v_d[k]    = slot_v_q[k-1] && !(br_taken && ((k - 1) < BR_SLOT));
      slot_rd_d[k]   = slot_rd_q[k-1];
      slot_load_d[k] = slot_load_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_v_q    <= '0;
      slot_load_q <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_q[k] <= '0;
      end
    end else begin
      slot_v_q    <= slot_v_d;
      slot_load_q <= slot_load_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_q[k] <= slot_rd_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on the default configuration
// plus hand sequences for reset, no-forwarding and counter saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [1:0] id_rs;
  logic       id_rs_used;
  logic [1:0] id_rd;
  logic       id_wr;
  logic       id_load;
  logic       br_taken;

  logic       a_stall, a_flush, a_issue;
  logic [1:0] a_fwd, a_pend;
  logic [7:0] a_cnt;
  logic       b_stall, b_flush, b_issue;
  logic [1:0] b_fwd, b_pend;
  logic [7:0] b_cnt;
  logic       c_stall, c_flush, c_issue;
  logic [1:0] c_fwd, c_pend;
  logic [1:0] c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.NREG_BITS(2), .DEPTH(3), .BR_SLOT(1), .FWD_EN(1), .CNT_W(8)) dut_a (
    .clock(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .br_taken(br_taken), .stall(a_stall), .flush(a_flush), .issue(a_issue),
    .fwd_sel(a_fwd), .pending(a_pend), .stall_cnt(a_cnt));

  hazard_ctrl #(.NREG_BITS(2), .DEPTH(3), .BR_SLOT(1), .FWD_EN(0), .CNT_W(8)) dut_b (
    .clock(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .br_taken(br_taken), .stall(b_stall), .flush(b_flush), .issue(b_issue),
    .fwd_sel(b_fwd), .pending(b_pend), .stall_cnt(b_cnt));

  hazard_ctrl #(.NREG_BITS(2), .DEPTH(3), .BR_SLOT(1), .FWD_EN(0), .CNT_W(2)) dut_c (
    .clock(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .br_taken(br_taken), .stall(c_stall), .flush(c_flush), .issue(c_issue),
    .fwd_sel(c_fwd), .pending(c_pend), .stall_cnt(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] rs;
    logic       rs_used;
    logic [1:0] rd;
    logic       wr;
    logic       load;
    logic       br;
    logic       e_stall;
    logic       e_flush;
    logic       e_issue;
    logic [1:0] e_fwd;
    logic [1:0] e_pend;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(int v, int rs, int u, int rd, int w, int l, int b,
                              int es, int ef, int ei, int efw, int ep, int ec);
    vec_t r;
    r.valid   = 1'(v);
    r.rs      = 2'(rs);
    r.rs_used = 1'(u);
    r.rd      = 2'(rd);
    r.wr      = 1'(w);
    r.load    = 1'(l);
    r.br      = 1'(b);
    r.e_stall = 1'(es);
    r.e_flush = 1'(ef);
    r.e_issue = 1'(ei);
    r.e_fwd   = 2'(efw);
    r.e_pend  = 2'(ep);
    r.e_cnt   = 8'(ec);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, required %0d", nm, idx, act, exp);
    end
  endtask

  task automatic set_in(input int v, input int rs, input int u, input int rd,
                        input int w, input int l, input int b);
    id_valid   = 1'(v);
    id_rs      = 2'(rs);
    id_rs_used = 1'(u);
    id_rd      = 2'(rd);
    id_wr      = 1'(w);
    id_load    = 1'(l);
    br_taken   = 1'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive a fresh instruction into ID just after the falling edge.
  task automatic step(input int v, input int rs, input int u, input int rd,
                      input int w, input int l, input int b);
    @(negedge clk);
    set_in(v, rs, u, rd, w, l, b);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: valid rs used rd wr load br | stall flush issue fwd pending cnt
    vecs[0]  = mk(1, 0, 0, 2, 1, 0, 0,  0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 2, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0);
    vecs[2]  = mk(1, 2, 1, 0, 0, 0, 0,  0, 0, 1, 2, 1, 0);
    vecs[3]  = mk(1, 2, 1, 1, 1, 1, 0,  0, 0, 1, 3, 1, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 2, 1, 1);
    vecs[6]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
    vecs[7]  = mk(1, 0, 0, 3, 1, 0, 0,  0, 0, 1, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1);
    vecs[9]  = mk(1, 3, 1, 0, 0, 0, 0,  0, 0, 1, 2, 1, 1);
    vecs[10] = mk(1, 0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 1, 1);
    vecs[11] = mk(1, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0, 1, 1);
    vecs[12] = mk(1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 2, 1, 0, 0,  0, 0, 1, 0, 0, 1);
    vecs[14] = mk(1, 0, 0, 3, 1, 0, 0,  0, 0, 1, 0, 1, 1);
    vecs[15] = mk(1, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0, 2, 1);
    vecs[16] = mk(1, 2, 1, 0, 0, 0, 0,  0, 0, 1, 3, 1, 1);

    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #2;
    chk("rst_a_stall", 0, int'(a_stall), 0);
    chk("rst_a_pend",  0, int'(a_pend),  0);
    chk("rst_a_cnt",   0, int'(a_cnt),   0);
    chk("rst_b_cnt",   0, int'(b_cnt),   0);
    chk("rst_c_cnt",   0, int'(c_cnt),   0);
    chk("rst_a_fwd",   0, int'(a_fwd),   0);

    // Table on the forwarding configuration.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].valid, vecs[i].rs, vecs[i].rs_used, vecs[i].rd,
           vecs[i].wr, vecs[i].load, vecs[i].br);
      chk("vec_stall", i, int'(a_stall), int'(vecs[i].e_stall));
      chk("vec_flush", i, int'(a_flush), int'(vecs[i].e_flush));
      chk("vec_issue", i, int'(a_issue), int'(vecs[i].e_issue));
      chk("vec_fwd",   i, int'(a_fwd),   int'(vecs[i].e_fwd));
      chk("vec_pend",  i, int'(a_pend),  int'(vecs[i].e_pend));
      chk("vec_cnt",   i, int'(a_cnt),   int'(vecs[i].e_cnt));
      $display("vec %0d: stall=%0d flush=%0d issue=%0d fwd=%0d pend=%0d cnt=%0d",
               i, a_stall, a_flush, a_issue, a_fwd, a_pend, a_cnt);
    end

    // Reset asserted mid-stall with a non-zero stall count.
    do_reset();
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("mid_stall", 0, int'(a_stall), 1);
    chk("mid_pend",  0, int'(a_pend),  3);
    step(1, 1, 1, 1, 1, 1, 0);
    chk("mid_fwd",   0, int'(a_fwd),   2);
    chk("mid_issue", 0, int'(a_issue), 1);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("mid_stall", 1, int'(a_stall), 1);
    chk("mid_cnt",   1, int'(a_cnt),   1);
    chk("mid_pend",  1, int'(a_pend),  2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_stall", 0, int'(a_stall), 0);
    chk("arst_fwd",   0, int'(a_fwd),   0);
    chk("arst_pend",  0, int'(a_pend),  0);
    chk("arst_cnt",   0, int'(a_cnt),   0);
    chk("arst_issue", 0, int'(a_issue), 1);
    chk("arst_flush", 0, int'(a_flush), 0);
    $display("reset mid-stall: stall=%0d fwd=%0d pend=%0d cnt=%0d", a_stall, a_fwd, a_pend, a_cnt);
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1, 0, 0, 2, 1, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0);
    chk("post_rst_fwd",  0, int'(a_fwd),  1);
    chk("post_rst_pend", 0, int'(a_pend), 1);
    chk("post_rst_cnt",  0, int'(a_cnt),  0);

    // No forwarding: dependent ALU op waits for writeback.
    do_reset();
    step(1, 0, 0, 3, 1, 0, 0);
    chk("nofwd_issue0", 0, int'(b_issue), 1);
    for (int c = 0; c < 4; c++) begin
      step(1, 3, 1, 0, 0, 0, 0);
      chk("nofwd_stall", c, int'(b_stall), (c < 3) ? 1 : 0);
      chk("nofwd_issue", c, int'(b_issue), (c == 3) ? 1 : 0);
      chk("nofwd_fwd",   c, int'(b_fwd),   0);
      chk("nofwd_cnt",   c, int'(b_cnt),   c);
      $display("nofwd cycle %0d: stall=%0d issue=%0d cnt=%0d", c, b_stall, b_issue, b_cnt);
    end

    // Two writers of r1 in flight: youngest wins, then a held dependency chain.
    do_reset();
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    begin
      int st_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      int cn_pat [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
      for (int i = 0; i < 8; i++) begin
        step(1, 1, 1, 1, 1, 0, 0);
        if (i == 0) begin
          chk("young_a_fwd",   0, int'(a_fwd),   1);
          chk("young_a_stall", 0, int'(a_stall), 0);
          chk("young_b_stall", 0, int'(b_stall), 1);
          chk("young_b_fwd",   0, int'(b_fwd),   0);
        end
        chk("sat_stall", i, int'(c_stall), st_pat[i]);
        chk("sat_cnt",   i, int'(c_cnt),   cn_pat[i]);
        chk("sat_fwd",   i, int'(c_fwd),   0);
        $display("sat cycle %0d: stall=%0d cnt=%0d", i, c_stall, c_cnt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
